// File: rtl/mem_access_unit.sv
// Memory access sequencer: turns byte-addressed LW/LH/LB/SW/SH/SB requests into
// word transactions on a synchronous 32-bit memory, with RMW for sub-word stores.
module mem_access_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   output logic [31:0] rdata,
   output logic        busy,
   output logic        done,
   output logic        misalign
);

   typedef enum logic [2:0] {
      S_IDLE, S_READ, S_CAPTURE, S_WRITE, S_DONE, S_ERR
   } state_t;

   typedef enum logic [2:0] {
      OP_LW = 3'b000, OP_LH = 3'b001, OP_LB = 3'b010,
      OP_SW = 3'b011, OP_SH = 3'b100, OP_SB = 3'b101
   } op_t;

   state_t      r_state, w_next;
   logic [2:0]  r_op;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_word;
   logic [31:0] w_load;
   logic [31:0] w_merged;
   logic        w_mis;
   logic        w_inv;
   logic        w_subst;

   always_comb begin
      w_mis = 1'b0;
      w_inv = 1'b0;
      case (op_t'(op))
         OP_LW, OP_SW: w_mis = (addr[1:0] != 2'b00);
         OP_LH, OP_SH: w_mis = addr[0];
         OP_LB, OP_SB: w_mis = 1'b0;
         default:      w_inv = 1'b1;
      endcase
   end

   assign w_subst = (op_t'(r_op) == OP_SH) || (op_t'(r_op) == OP_SB);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_mis)                     w_next = S_ERR;
               else if (w_inv)                w_next = S_DONE;
               else if (op_t'(op) == OP_SW)   w_next = S_WRITE;
               else                           w_next = S_READ;
            end
         end
         S_READ:    w_next = S_CAPTURE;
         S_CAPTURE: w_next = w_subst ? S_WRITE : S_DONE;
         S_WRITE:   w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         S_ERR:     w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_load = mem_rdata;
      case (op_t'(r_op))
         OP_LH:   w_load = {16'h0000, r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0]};
         OP_LB:   w_load = {24'h000000, mem_rdata[{r_addr[1:0], 3'b000} +: 8]};
         default: w_load = mem_rdata;
      endcase
   end

   always_comb begin
      w_merged = mem_rdata;
      if (op_t'(r_op) == OP_SH)
         w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      else if (op_t'(r_op) == OP_SB)
         w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_op    <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_word  <= '0;
         rdata   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && start) begin
            r_op    <= op;
            r_addr  <= addr;
            r_wdata <= wdata;
         end
         if (r_state == S_CAPTURE) begin
            r_word <= w_merged;
            if (!w_subst)
               rdata <= w_load;
         end
      end
   end

   assign mem_addr  = {r_addr[31:2], 2'b00};
   // Reset gates the write strobe so a reset landing in WRITE leaves memory untouched.
   assign mem_wr    = (r_state == S_WRITE) && !reset;
   assign mem_wdata = (op_t'(r_op) == OP_SW) ? r_wdata : r_word;
   assign busy      = (r_state != S_IDLE);
   assign done      = (r_state == S_DONE) || (r_state == S_ERR);
   assign misalign  = (r_state == S_ERR);

endmodule
